histo_reader: RTL and testbench

Readout sequencer for the trigger board's per-channel monitoring histograms. The trigger logic writes them; this block reads them. On a start pulse it steps the histogram select index over every input channel and waits out the select-to-data pipeline. It captures the 8 monitoring words for each channel and serialises them as a framed byte stream over a valid/ready handshake toward the host link. It can optionally clear each channel's histograms immediately after reading them. It runs in the ADC clock domain, alongside the trigger logic.

---
 rtl/trig_pkg.sv | 21 ++
 rtl/byte_serializer.sv | 49 ++++
 rtl/histo_reader.sv | 157 +++++++++++++++
 tb/tb_histo_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants and state encoding for the trigger-board histogram readout.
package trig_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] TRL_BYTE  = 8'h5A;
    localparam int         NHIST_DEF = 8;
    localparam int         LAT_DEF   = 3;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        WAIT,
        CAPT,
        SEND,
        CLR,
        HOLD,
        TRL,
        DONE
    } state_e;

endpackage

// File: rtl/byte_serializer.sv
// Snapshots one channel's histogram words and walks them out byte by byte,
// big-endian within each word, advancing only on an accepted transfer.
module byte_serializer
    import trig_pkg::*;
#(
    parameter int NHIST = NHIST_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load_i,
    input  logic [NHIST*32-1:0]   data_i,
    input  logic                  send_i,
    input  logic                  accept_i,
    output logic [7:0]            first_byte_o,
    output logic [7:0]            next_byte_o,
    output logic                  last_byte_accepted_o
);

    localparam int NBYTES = NHIST * 4;
    localparam int BW     = $clog2(NBYTES);

    logic [NHIST*32-1:0] shadow_q;
    logic [BW-1:0]       byte_q;

    // Byte b lives in word b/4, byte lane 3-(b%4); indices past the end read as zero.
    function automatic logic [7:0] pick(input logic [NHIST*32-1:0] v, input int unsigned b);
        return 8'(v >> (32 * (b / 4) + 8 * (3 - (b % 4))));
    endfunction

    assign first_byte_o         = pick(data_i, 0);
    assign next_byte_o          = pick(shadow_q, 32'(byte_q) + 1);
    assign last_byte_accepted_o = send_i && accept_i && (byte_q == BW'(NBYTES - 1));

    // NOTE: the shadow is an ordinary register bank, so it takes the async reset
    // like everything else; non-blocking assignments keep all state updates
    // evaluated against the same pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_q <= '0;
            byte_q   <= '0;
        end else if (load_i) begin
            shadow_q <= data_i;
            byte_q   <= '0;
        end else if (send_i && accept_i) begin
            byte_q   <= byte_q + 1'b1;
        end
    end

endmodule

// File: rtl/histo_reader.sv
// Readout sequencer: scans every channel's monitoring histograms, streams them
// as a framed byte sequence and optionally clears each channel after reading.
module histo_reader
    import trig_pkg::*;
#(
    parameter int NCHAN   = 64,
    parameter int NHIST   = NHIST_DEF,
    parameter int LAT     = LAT_DEF,
    parameter int CLR_LEN = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                clear_after_read,
    output logic [7:0]          hist_idx,
    input  logic [NHIST*32-1:0] hist_in,
    output logic                resethist,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_count
);

    state_e      state_q;
    logic [7:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [7:0]  tx_data_q;
    logic        clr_en_q;
    logic        resethist_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] frame_count_q;

    logic        accept;
    logic        last_chan;
    logic        ser_last;
    logic [7:0]  first_byte;
    logic [7:0]  next_byte;

    assign accept    = tx_valid_q && tx_ready;
    assign last_chan = (idx_q == 8'(NCHAN - 1));

    byte_serializer #(.NHIST(NHIST)) u_ser (
        .clk                  (clk),
        .nrst                 (nrst),
        .load_i               (state_q == CAPT),
        .data_i               (hist_in),
        .send_i               (state_q == SEND),
        .accept_i             (accept),
        .first_byte_o         (first_byte),
        .next_byte_o          (next_byte),
        .last_byte_accepted_o (ser_last)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            clr_en_q      <= 1'b0;
            resethist_q   <= 1'b0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    clr_en_q   <= clear_after_read;
                    idx_q      <= '0;
                    busy_q     <= 1'b1;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= HDR_BYTE;
                    state_q    <= HDR;
                end
                HDR: if (accept) begin
                    tx_valid_q <= 1'b0;
                    cnt_q      <= 8'(LAT - 1);
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= CAPT;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                CAPT: begin
                    tx_data_q  <= first_byte;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (accept) begin
                    if (!ser_last) begin
                        tx_data_q <= next_byte;
                    end else if (clr_en_q) begin
                        tx_valid_q  <= 1'b0;
                        resethist_q <= 1'b1;
                        cnt_q       <= 8'(CLR_LEN - 1);
                        state_q     <= CLR;
                    end else if (last_chan) begin
                        tx_data_q <= TRL_BYTE;
                        state_q   <= TRL;
                    end else begin
                        tx_valid_q <= 1'b0;
                        idx_q      <= idx_q + 1'b1;
                        cnt_q      <= 8'(LAT - 1);
                        state_q    <= WAIT;
                    end
                end
                CLR: begin
                    if (cnt_q == '0) begin
                        resethist_q <= 1'b0;
                        cnt_q       <= 8'(LAT - 1);
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // The clear reaches the histograms LAT cycles late; keep the index parked until it lands.
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (last_chan) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= TRL_BYTE;
                        state_q    <= TRL;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= 8'(LAT - 1);
                        state_q <= WAIT;
                    end
                end
                TRL: if (accept) begin
                    tx_valid_q    <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    frame_count_q <= frame_count_q + 1'b1;
                    state_q       <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hist_idx    = idx_q;
    assign resethist   = resethist_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_histo_reader.sv
// Scoreboard bench for histo_reader: a latency-accurate histogram model feeds
// the DUT, expected frames are queued at start and popped on every accepted byte.
module tb_histo_reader;
    import trig_pkg::*;

    localparam int NCHAN   = 64;
    localparam int NHIST   = 8;
    localparam int LAT     = 3;
    localparam int CLR_LEN = 2;
    localparam int NB      = NHIST * 4;
    localparam int BUDGET  = 15000;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic                start = 1'b0;
    logic                clear_after_read = 1'b0;
    logic                tx_ready = 1'b0;
    logic [7:0]          hist_idx;
    logic [NHIST*32-1:0] hist_in;
    logic                resethist;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                busy;
    logic                done;
    logic [15:0]         frame_count;

    logic [7:0]       idx_pipe [LAT];
    logic [LAT-1:0]   rst_pipe;
    logic [NCHAN-1:0] cleared;
    logic             restore = 1'b1;
    logic             alt3 = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_fc = '0;
    logic [7:0]  exp_q [$];

    histo_reader #(.NCHAN(NCHAN), .NHIST(NHIST), .LAT(LAT), .CLR_LEN(CLR_LEN)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .start            (start),
        .clear_after_read (clear_after_read),
        .hist_idx         (hist_idx),
        .hist_in          (hist_in),
        .resethist        (resethist),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input int ch, input int h, input bit alt);
        return {8'(ch), 8'(h), (alt && ch == 3) ? 16'hBEEF : 16'h1234};
    endfunction

    // Histogram memory model: select and clear both take LAT cycles to take effect.
    always @(posedge clk) begin
        idx_pipe[0] <= hist_idx;
        for (int i = 1; i < LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
        rst_pipe <= {rst_pipe[LAT-2:0], resethist};
        if (restore) cleared <= '0;
        else if (rst_pipe[LAT-1]) cleared[idx_pipe[LAT-1]] <= 1'b1;
    end

    always_comb begin
        hist_in = '0;
        for (int h = 0; h < NHIST; h++)
            hist_in[32*h +: 32] = cleared[idx_pipe[LAT-1]] ? 32'h0
                                : model_word(int'(idx_pipe[LAT-1]), h, alt3);
    end

    task automatic run_frame(input logic clr, input int ready_pct, input bit exp_zero,
                             input int abort_at, input bit poke, input bit snap);
        int          nbytes = 0;
        int          rst_cycles = 0;
        int          cyc = 0;
        bit          done_seen = 0;
        bit          aborted = 0;
        bit          stall_prev = 0;
        bit          rdy;
        logic [7:0]  prev_data = '0;
        logic [7:0]  exp_b;
        logic [31:0] w;
        logic [31:0] w52 = '0;

        exp_q.delete();
        exp_q.push_back(HDR_BYTE);
        for (int ch = 0; ch < NCHAN; ch++)
            for (int h = 0; h < NHIST; h++) begin
                w = exp_zero ? 32'h0 : model_word(ch, h, 1'b0);
                for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
            end
        exp_q.push_back(TRL_BYTE);
        if (abort_at == 0) exp_fc = exp_fc + 1'b1;

        start = 1'b1;
        clear_after_read = clr;
        @(negedge clk);
        start = 1'b0;
        clear_after_read = 1'b0;
        checks++;
        if (!(busy === 1'b1 && tx_valid === 1'b1 && tx_data === 8'hA5)) begin
            errors++;
            $display("FAIL start_latency: busy=%b valid=%b data=%h, required 1 1 a5", busy, tx_valid, tx_data);
        end

        while (!done_seen && cyc < BUDGET) begin
            start = 1'b0;
            if (abort_at > 0 && nbytes == abort_at) begin
                nrst = 1'b0;
                #1;
                checks++;
                if ({hist_idx, resethist, tx_data, tx_valid, busy, done, frame_count} !== 36'h0) begin
                    errors++;
                    $display("FAIL abort_outputs: got %h, required all zero",
                             {hist_idx, resethist, tx_data, tx_valid, busy, done, frame_count});
                end
                aborted = 1;
                break;
            end
            if (stall_prev) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h, required 1 %h", tx_valid, tx_data, prev_data);
                end
            end
            if (resethist === 1'b1) begin
                rst_cycles++;
                checks++;
                if (hist_idx !== 8'((nbytes - 1) / NB - 1)) begin
                    errors++;
                    $display("FAIL clear_idx: hist_idx=%0d, required %0d", hist_idx, (nbytes - 1) / NB - 1);
                end
            end
            if (done === 1'b1) begin
                done_seen = 1;
                checks++;
                if (busy !== 1'b0 || frame_count !== exp_fc) begin
                    errors++;
                    $display("FAIL done_cycle: busy=%b frame_count=%h, required 0 %h", busy, frame_count, exp_fc);
                end
                if (poke) start = 1'b1;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
                tx_ready = rdy;
                if (tx_valid === 1'b1 && rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %h at byte %0d, required no byte", tx_data, nbytes);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (tx_data !== exp_b) begin
                            errors++;
                            $display("FAIL stream_byte %0d: got %h, required %h", nbytes, tx_data, exp_b);
                        end
                    end
                    if (nbytes >= 1 + 5*NB + 8 && nbytes < 1 + 5*NB + 12) w52 = {w52[23:0], tx_data};
                    nbytes++;
                    if (snap && nbytes == 1 + 3*NB + 4) alt3 = 1'b1;
                    if (poke && nbytes == 100) start = 1'b1;
                end
                stall_prev = (tx_valid === 1'b1) && !rdy;
                prev_data  = tx_data;
            end
            @(negedge clk);
            cyc++;
        end

        if (aborted) begin
            tx_ready = 1'b0;
            @(negedge clk);
            nrst = 1'b1;
            @(negedge clk);
            exp_q.delete();
            exp_fc = '0;
            checks++;
            if (frame_count !== 16'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: frame_count=%h busy=%b, required 0000 0", frame_count, busy);
            end
            return;
        end

        start = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL frame_timeout: bytes=%0d after %0d cycles, required done", nbytes, cyc);
        end else if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b valid=%b, required 0 0 0", done, busy, tx_valid);
        end
        checks++;
        if (nbytes != 2 + NCHAN*NB) begin
            errors++;
            $display("FAIL byte_count: got %0d, required %0d", nbytes, 2 + NCHAN*NB);
        end
        checks++;
        if (rst_cycles != (clr ? CLR_LEN*NCHAN : 0)) begin
            errors++;
            $display("FAIL clear_cycles: got %0d, required %0d", rst_cycles, clr ? CLR_LEN*NCHAN : 0);
        end
        if (!exp_zero) begin
            checks++;
            if (w52 !== 32'h05021234) begin
                errors++;
                $display("FAIL ch5_word2: got %h, required 05021234", w52);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hist_idx, resethist, tx_data, tx_valid, busy, done, frame_count} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required all zero",
                     {hist_idx, resethist, tx_data, tx_valid, busy, done, frame_count});
        end
        nrst = 1'b1;
        restore = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_abort();
        run_frame(1'b0, 100, 1'b0, 700, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        run_frame(1'b0, 100, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_ready();
        run_frame(1'b0, 30, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        run_frame(1'b1, 100, 1'b0, 0, 1'b0, 1'b0);
        run_frame(1'b0, 100, 1'b1, 0, 1'b0, 1'b0);
        restore = 1'b1;
        @(negedge clk);
        restore = 1'b0;
    endtask

    task automatic test_snapshot();
        run_frame(1'b0, 100, 1'b0, 0, 1'b0, 1'b1);
        alt3 = 1'b0;
    endtask

    task automatic test_ignored_start();
        run_frame(1'b0, 100, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.frame_count_q = 16'hFFFF;
        exp_fc = 16'hFFFF;
        @(negedge clk);
        run_frame(1'b0, 100, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (frame_count !== 16'h0000) begin
            errors++;
            $display("FAIL frame_wrap: got %h, required 0000", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_basic();
        test_random_ready();
        test_clear();
        test_snapshot();
        test_ignored_start();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
